// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared constants and types for the instruction-fetch stage.
//   INST_W        : instruction word width.
//   PC_INC        : byte distance between consecutive sequential fetches.
//   ENTRY_PC_W    : PC width carried by fetch_entry_t (default fetch width).
//   fetch_entry_t : one decoded-bound entry, {pc, data}.
// ----------------------------------------------------------------------------
package if_pkg;

    localparam int INST_W     = 32;
    localparam int PC_INC     = 4;
    localparam int ENTRY_PC_W = 32;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [INST_W-1:0]     data;
    } fetch_entry_t;

endpackage : if_pkg

// File: rtl/if_fetch_unit_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a synchronous clear. Used for both the tag queue
// (PCs of live in-flight requests) and the instruction queue ({pc, data}).
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : empties the FIFO at the next edge; overrides push and pop
//   push       : write push_data (ignored when full unless popping too)
//   pop        : retire the head entry (ignored when empty)
//   pop_data   : head entry, meaningful only when !empty
//   count      : number of stored entries, 0..DEPTH
//   full/empty : status flags derived from count
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default at the top of always_comb so no path
    //       leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    //       pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are
    //       only observed through count/empty, which are reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
    end

endmodule : sync_fifo

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Decoupled, pipelined instruction fetch. Issues in-order word requests to an
// instruction memory of arbitrary latency, pairs each response with its PC
// and buffers it for decode. Redirects flush everything and discard the
// responses of requests still in flight for the old path.
//   clk, rst                        : clock, asynchronous active-high reset
//   redirect_valid / redirect_pc    : taken branch/jump; pc[1:0] ignored
//   imem_req_valid/ready/addr       : request channel (word address)
//   imem_rsp_valid / imem_rsp_data  : in-order response, no back-pressure
//   inst_valid/ready, inst_data/pc  : instruction stream to decode
// Credit: a request may be presented only while in-flight (live + stale)
// plus buffered instructions is below DEPTH, so neither queue can overflow
// and responses never need back-pressure.
// ----------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WIDTH-1:0]  imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [WIDTH-1:0]  inst_pc
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = WIDTH + INST_W;

    logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               fifo_clr;
    logic               tag_push, tag_pop;
    logic [WIDTH-1:0]   tag_pc;
    logic [CNT_W-1:0]   tag_count;
    logic               tag_full, tag_empty;

    logic               inst_push, inst_pop;
    logic [ENTRY_W-1:0] inst_entry;
    logic [CNT_W-1:0]   inst_count;
    logic               inst_full, inst_empty;

    logic [SUM_W-1:0]   in_use;
    logic [SUM_W-1:0]   stale_sum;
    logic               req_fire;

    // Credit depends on state only, never on imem_req_ready.
    assign in_use         = SUM_W'(tag_count) + SUM_W'(drop_cnt_q) + SUM_W'(inst_count);
    assign imem_req_valid = (in_use < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Outputs read as zero while the queue is empty, so reset shows 0.
    assign inst_valid = !inst_empty;
    assign inst_pc    = inst_valid ? inst_entry[ENTRY_W-1:INST_W] : '0;
    assign inst_data  = inst_valid ? inst_entry[INST_W-1:0]       : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        fifo_clr   = 1'b0;
        tag_push   = 1'b0;
        tag_pop    = 1'b0;
        inst_push  = 1'b0;
        inst_pop   = 1'b0;
        stale_sum  = SUM_W'(drop_cnt_q) + SUM_W'(tag_count) + SUM_W'(req_fire);

        if (redirect_valid) begin
            // Everything outstanding, including a request firing right now,
            // belongs to the old path. A response this cycle retires the
            // oldest of them.
            fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
            fifo_clr   = 1'b1;
            if (imem_rsp_valid && (stale_sum != '0)) begin
                stale_sum = stale_sum - SUM_W'(1);
            end
            drop_cnt_d = stale_sum[CNT_W-1:0];
        end else begin
            if (req_fire) begin
                tag_push   = 1'b1;
                fetch_pc_d = fetch_pc_q + WIDTH'(PC_INC);
            end
            // Stale requests are always older than live ones, so drops are
            // consumed before any tag is popped.
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else if (!tag_empty) begin
                    tag_pop   = 1'b1;
                    inst_push = 1'b1;
                end
            end
            inst_pop = inst_valid && inst_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (tag_push),
        .push_data (fetch_pc_q),
        .pop       (tag_pop),
        .pop_data  (tag_pc),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (inst_push),
        .push_data ({tag_pc, imem_rsp_data}),
        .pop       (inst_pop),
        .pop_data  (inst_entry),
        .count     (inst_count),
        .full      (inst_full),
        .empty     (inst_empty)
    );

    // A response with nothing outstanding breaks the memory protocol; it is
    // ignored by the logic above.
    a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (drop_cnt_q == '0) && tag_empty))
        else $error("if_fetch_unit: response with no outstanding request");

    // The credit rule must keep both queues from overflowing.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(tag_push && tag_full) && !(inst_push && inst_full && !inst_pop))
        else $error("if_fetch_unit: queue overflow");

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam int          TB_DEPTH = 4;
    localparam logic [31:0] TB_RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // Narrow instance used only for the address wrap check.
    logic        r8_redirect_valid;
    logic [7:0]  r8_redirect_pc;
    logic        r8_req_valid;
    logic        r8_req_ready;
    logic [7:0]  r8_req_addr;
    logic        r8_inst_valid;
    logic [31:0] r8_inst_data;
    logic [7:0]  r8_inst_pc;

    if_fetch_unit #(.WIDTH(32), .RESET_PC(TB_RESET_PC), .DEPTH(TB_DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    if_fetch_unit #(.WIDTH(8), .RESET_PC(8'h0), .DEPTH(TB_DEPTH)) u_dut8 (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (r8_redirect_valid),
        .redirect_pc    (r8_redirect_pc),
        .imem_req_valid (r8_req_valid),
        .imem_req_ready (r8_req_ready),
        .imem_req_addr  (r8_req_addr),
        .imem_rsp_valid (1'b0),
        .imem_rsp_data  (32'h0),
        .inst_valid     (r8_inst_valid),
        .inst_ready     (1'b0),
        .inst_data      (r8_inst_data),
        .inst_pc        (r8_inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;
    int lat;
    bit chk_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory and reference model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } flight_t;

    mreq_t        mem_q[$];
    flight_t      m_flight[$];   // every outstanding request, oldest first
    fetch_entry_t m_inst[$];     // instructions waiting for decode
    logic [31:0]  m_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit m_req_valid();
        return (m_flight.size() + m_inst.size()) < TB_DEPTH;
    endfunction

    // Advance one clock: apply the spec rules to the model using the inputs
    // that were present during the cycle, then present the next response.
    task automatic tick();
        bit      fire;
        bit      pop;
        flight_t f;
        @(posedge clk);
        fire = m_req_valid() && imem_req_ready;
        pop  = (m_inst.size() > 0) && inst_ready;
        if (fire) mem_q.push_back('{addr: m_pc, due: cyc + lat});
        if (redirect_valid) begin
            if (imem_rsp_valid && m_flight.size() > 0) f = m_flight.pop_front();
            foreach (m_flight[i]) m_flight[i].stale = 1'b1;
            if (fire) m_flight.push_back('{pc: m_pc, stale: 1'b1});
            m_inst.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) void'(m_inst.pop_front());
            if (imem_rsp_valid && m_flight.size() > 0) begin
                f = m_flight.pop_front();
                if (!f.stale) m_inst.push_back('{pc: f.pc, data: mem_word(f.pc)});
            end
            if (fire) begin
                m_flight.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        chk_en         = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_q.delete();
        m_flight.delete();
        m_inst.delete();
        m_pc = TB_RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cyc    = 1;
        chk_en = 1'b1;
    endtask

    // ---------------- per-cycle compare against the model ----------------
    bit          e_v;
    logic [31:0] e_pc;
    logic [31:0] e_data;

    always @(negedge clk) begin
        if (chk_en) begin
            e_v    = m_inst.size() > 0;
            e_pc   = e_v ? m_inst[0].pc   : 32'h0;
            e_data = e_v ? m_inst[0].data : 32'h0;
            check("req_valid", imem_req_valid, m_req_valid());
            if (m_req_valid()) check("req_addr", imem_req_addr, m_pc);
            check("inst_valid", inst_valid, e_v);
            check("inst_pc", inst_pc, e_pc);
            check("inst_data", inst_data, e_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed and random stimulus ----------------
    int fires;
    int first_cyc;

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        cyc               = 0;
        chk_en            = 1'b0;
        rst               = 1'b1;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        imem_req_ready    = 1'b0;
        imem_rsp_valid    = 1'b0;
        imem_rsp_data     = 32'h0;
        inst_ready        = 1'b0;
        r8_redirect_valid = 1'b0;
        r8_redirect_pc    = 8'h0;
        r8_req_ready      = 1'b0;

        // 1: sequential stream, 1-cycle memory, decode always ready
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        check("t1_rst_inst_valid", inst_valid, 1'b0);
        check("t1_rst_inst_pc", inst_pc, 32'h0);
        check("t1_rst_inst_data", inst_data, 32'h0);
        check("t1_addr_c1", imem_req_addr, 32'h0);
        check("t1_req_valid_c1", imem_req_valid, 1'b1);
        tick();
        check("t1_addr_c2", imem_req_addr, 32'h4);
        check("t1_inst_valid_c2", inst_valid, 1'b0);
        tick();
        check("t1_inst_valid_c3", inst_valid, 1'b1);
        check("t1_inst_pc_c3", inst_pc, 32'h0);
        check("t1_inst_data_c3", inst_data, mem_word(32'h0));
        for (int k = 1; k < 6; k++) begin
            tick();
            check("t1_stream_valid", inst_valid, 1'b1);
            check("t1_stream_pc", inst_pc, 32'(4 * k));
        end

        // 2: decode stalled, credit limit of 4
        inst_ready = 1'b0;
        do_reset();
        fires = 0;
        for (int k = 0; k < 10; k++) begin
            if (imem_req_valid) fires++;
            tick();
        end
        check("t2_fires", fires, 4);
        check("t2_req_valid_full", imem_req_valid, 1'b0);
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_valid", inst_valid, 1'b1);
            check("t2_drain_pc", inst_pc, 32'(4 * k));
            check("t2_drain_data", inst_data, mem_word(32'(4 * k)));
            tick();
            if (k == 0) check("t2_credit_back", imem_req_valid, 1'b1);
        end

        // 3: 3-cycle memory, 2 outstanding, redirect to 0x100
        lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        check("t3_target_addr", imem_req_addr, 32'h100);
        first_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (inst_valid) begin
                first_cyc = cyc;
                break;
            end
            tick();
        end
        check("t3_first_valid_cycle", first_cyc, 8);
        check("t3_first_pc", inst_pc, 32'h100);
        check("t3_first_data", inst_data, mem_word(32'h100));

        // 4: redirect together with req fire, rsp and inst pop
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        repeat (4) tick();
        check("t4_pre_inst_valid", inst_valid, 1'b1);
        check("t4_pre_req_valid", imem_req_valid, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("t4_flushed", inst_valid, 1'b0);
        check("t4_target_addr", imem_req_addr, 32'h200);
        check("t4_target_req_valid", imem_req_valid, 1'b1);
        tick();
        check("t4_stale_dropped", inst_valid, 1'b0);
        tick();
        check("t4_target_valid", inst_valid, 1'b1);
        check("t4_target_pc", inst_pc, 32'h200);

        // 5: address masking and wrap (32-bit and 8-bit instances)
        do_reset();
        redirect_valid    = 1'b1; redirect_pc    = 32'h102;
        r8_redirect_valid = 1'b1; r8_redirect_pc = 8'hFC;
        tick();
        redirect_valid    = 1'b0;
        r8_redirect_valid = 1'b0;
        check("t5_mask_addr", imem_req_addr, 32'h100);
        check("t5_w8_addr_fc", r8_req_addr, 8'hFC);
        check("t5_w8_req_valid", r8_req_valid, 1'b1);
        r8_req_ready   = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        r8_req_ready   = 1'b0;
        check("t5_w8_wrap", r8_req_addr, 8'h00);
        check("t5_w8_inst_valid", r8_inst_valid, 1'b0);
        check("t5_w8_inst_pc", r8_inst_pc, 8'h00);
        check("t5_w8_inst_data", r8_inst_data, 32'h0);
        check("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("t5_wrap", imem_req_addr, 32'h0);

        // 6: asynchronous reset while busy
        lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b0;
        do_reset();
        repeat (3) tick();
        check("t6_pre_busy", inst_valid, 1'b1);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_inst_valid", inst_valid, 1'b0);
        check("t6_rst_addr", imem_req_addr, TB_RESET_PC);
        check("t6_rst_inst_pc", inst_pc, 32'h0);
        do_reset();
        check("t6_restart_addr", imem_req_addr, TB_RESET_PC);
        tick();
        check("t6_restart_next", imem_req_addr, TB_RESET_PC + 32'd4);

        // 7: randomized traffic, latency and redirects against the model
        for (int ph = 0; ph < 8; ph++) begin
            lat = $urandom_range(1, 4);
            do_reset();
            for (int k = 0; k < 300; k++) begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                inst_ready     = (ph % 2 == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
                redirect_valid = ($urandom_range(0, 15) == 0);
                redirect_pc    = $urandom;
                tick();
            end
            redirect_valid = 1'b0;
        end

        @(posedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_if_fetch_unit

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage that replaces the single-cycle fetch with a decoupled, pipelined fetch engine. It issues in-order word requests to an instruction memory with arbitrary response latency and buffers returned instructions with their PCs in a prefetch queue. The queue feeds decode over a valid/ready handshake. It accepts taken-branch/jump redirects at any time, flushes the queue, and discards responses still in flight for the stale path.

## Interface
Parameters:
- WIDTH, 32: PC / address width.
- RESET_PC, 0: PC loaded on reset. Must be 4-byte aligned.
- DEPTH, 4: maximum in-flight requests plus buffered instructions. Must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  taken branch/jump this cycle. Upstream supplies branch & ALU_zero or a jump.
- redirect_pc  in  WIDTH  new fetch target. Bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  WIDTH  word address of the request.
- imem_rsp_valid  in  1  response valid. Responses arrive in order and cannot be back-pressured.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes the instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  WIDTH  PC of inst_data.

## Operation
- State:
  - fetch_pc.
  - Tag queue: PCs of live in-flight requests, DEPTH entries.
  - Inst queue: {pc, data} pairs, DEPTH entries.
  - drop_cnt: stale in-flight requests, 0..DEPTH.
- Credit: imem_req_valid = (tag_count + drop_cnt + inst_count) < DEPTH.
  - imem_req_valid depends only on state and never on imem_req_ready.
  - imem_req_addr = fetch_pc.
- Request fire (valid & ready):
  - push fetch_pc into the tag queue;
  - fetch_pc += 4, wrapping modulo 2^WIDTH.
- Response:
  - If drop_cnt > 0, discard the data and decrement drop_cnt.
  - Otherwise pop the tag queue and push {tag, data} into the inst queue.
- Inst output: inst_valid = inst queue not empty; pop on inst_valid & inst_ready.
- Redirect, which takes precedence over everything else in that cycle:
  - fetch_pc ← redirect_pc & ~3;
  - inst queue cleared, and any same-cycle pop is ignored;
  - tag queue cleared;
  - drop_cnt ← drop_cnt + tag_count + req_fire − rsp_valid.
  - A request firing in the redirect cycle carries the old address and is counted as stale.
  - A response arriving in the redirect cycle is discarded.
- A response with the tag queue empty and drop_cnt = 0 is a protocol violation. It is ignored and flagged by a simulation assertion.
- Reset values:
  - fetch_pc = RESET_PC;
  - all counts 0 and queues empty;
  - imem_req_valid = 1 once rst falls;
  - inst_valid = 0;
  - inst_data and inst_pc = 0.

## Timing
- First request is presented in the first cycle after rst deasserts.
- No bypass: an instruction appears on inst_* in the cycle after its response is accepted.
- With a 1-cycle memory (rsp the cycle after req fire), redirect at cycle t gives:
  - request for the target at t+1;
  - response at t+2;
  - inst_valid at t+3.
- Throughput:
  - Sustains 1 instruction/cycle when DEPTH ≥ memory latency + 2.
  - With a lower DEPTH, throughput is credit-limited but still correct.
- Full (credit 0): imem_req_valid is low, and rises the cycle after a pop or after a stale response drains.
- Back-to-back redirects: each redirect overrides the previous one. drop_cnt accumulates and never exceeds DEPTH.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronously). Responses arriving after reset for pre-reset requests are outside the contract.

## Structure
- Shared package if_pkg holds:
  - INST_W = 32;
  - PC_INC = 4;
  - the fetch-entry typedef {pc, data}.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), with push, pop, synchronous clear, count, full and empty. It is instantiated twice: once for the tag queue and once for the inst queue.
- if_fetch_unit holds fetch_pc, drop_cnt, the credit logic and the redirect logic.

## Test plan
- Reset, 1-cycle memory, inst_ready = 1:
  - required: imem_req_addr sequence 0, 4, 8, …;
  - inst_pc 0 with inst_valid first at cycle 3;
  - then one instruction per cycle thereafter.
- Decode stalled (inst_ready = 0), DEPTH = 4:
  - required: exactly 4 requests fire, then imem_req_valid = 0;
  - releasing the stall yields PCs 0, 4, 8, 12 in order with their matching data.
- 3-cycle memory latency with 2 requests outstanding, redirect to 0x100:
  - required: both stale responses are dropped;
  - next inst_pc = 0x100;
  - no stale PC ever appears on inst_*.
- Redirect in the same cycle as a req fire, a rsp and an inst pop:
  - required: the fired request counts as stale;
  - the response is dropped;
  - the queue is empty the next cycle;
  - the target 0x200 is fetched the next cycle.
- Redirect to 0x102:
  - required: imem_req_addr = 0x100.
- With WIDTH = 8 and fetch_pc = 0xFC:
  - required: the next address after 0xFC is 0x00.
- Assert rst while requests and queue are occupied:
  - required: the same cycle shows inst_valid = 0 and fetch_pc = RESET_PC;
  - fetching restarts at RESET_PC after release.
